// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types.
// FSM state encoding and requester indices.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPT,
        DONE
    } state_e;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of mem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          boot;
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] adress;
    logic [DW-1:0] data;
    logic          memRead;
    logic          memWrite;
    logic [DW-1:0] memOut;

    modport slave (
        input  boot, req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1, memOut,
        output gnt0, gnt1, done0, done1, rdata,
        output adress, data, memRead, memWrite
    );

    modport master (
        output boot, req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1, memOut,
        input  gnt0, gnt1, done0, done1, rdata,
        input  adress, data, memRead, memWrite
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin chooser.
// On a tie the requester that did not win last time is picked.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       valid,
    output logic       winner
);
    always_comb begin
        valid  = |eligible;
        winner = eligible[REQ_LOAD];
        if (&eligible) begin
            winner = ~last;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and sequencer for single-port main memory.
// Registered Moore outputs; fixed read latency of MEM_LAT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          pick_valid;
    logic          pick_winner;
    logic          busy;

    rr_pick2 u_pick (
        .eligible ({bus.req1, bus.req0 & ~bus.boot}),
        .last     (last_q),
        .valid    (pick_valid),
        .winner   (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    win_d   = pick_winner;
                    if (pick_winner == REQ_LOAD) begin
                        we_d    = bus.we1;
                        addr_d  = bus.addr1;
                        wdata_d = bus.wdata1;
                    end else begin
                        we_d    = bus.we0;
                        addr_d  = bus.addr0;
                        wdata_d = bus.wdata0;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = (MEM_LAT > 1) ? WAIT : CAPT;
            end
            WAIT: begin
                // Stop counting once the last wait cycle is reached.
                if (cnt_q >= CNT_LAST) begin
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPT: begin
                if (!we_q) begin
                    rdata_d = bus.memOut;
                end
                state_d = DONE;
            end
            DONE: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs decode the next state so they come straight from flops.
        busy    = (state_d != IDLE);
        gnt0_d  = busy && (win_d == REQ_CPU);
        gnt1_d  = busy && (win_d == REQ_LOAD);
        done0_d = (state_d == DONE) && (win_d == REQ_CPU);
        done1_d = (state_d == DONE) && (win_d == REQ_LOAD);
        rd_d    = (state_d == ISSUE) && !we_d;
        wr_d    = (state_d == ISSUE) && we_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= REQ_LOAD;
            win_q   <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.rdata    = rdata_q;
    assign bus.adress   = addr_q;
    assign bus.data     = wdata_q;
    assign bus.memRead  = rd_q;
    assign bus.memWrite = wr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1,
// one at MEM_LAT=3, each with its own latency-accurate memory model.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_arbiter_if #(.AW(32), .DW(32)) if1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) if3 ();

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    logic [31:0] m1 [256];
    logic [31:0] m3 [256];
    logic [31:0] p1;
    logic [31:0] p3 [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1 <= if1.memRead ? m1[if1.adress[7:0]] : 32'hDEADBEEF;
        p3[0] <= if3.memRead ? m3[if3.adress[7:0]] : 32'hDEADBEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (if3.memWrite) m3[if3.adress[7:0]] <= if3.data;
    end

    assign if1.memOut = p1;
    assign if3.memOut = p3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if1.boot = 0; if1.req0 = 0; if1.req1 = 0;
        if1.we0 = 0; if1.we1 = 0;
        if1.addr0 = 0; if1.addr1 = 0;
        if1.wdata0 = 0; if1.wdata1 = 0;
        if3.boot = 0; if3.req0 = 0; if3.req1 = 0;
        if3.we0 = 0; if3.we1 = 0;
        if3.addr0 = 0; if3.addr1 = 0;
        if3.wdata0 = 0; if3.wdata1 = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        logic [3:0] o1;
        logic [3:0] o3;
        reset = 1;
        tick();
        tick();
        tick();
        o1 = {if1.gnt0, if1.gnt1, if1.done0, if1.done1};
        o3 = {if3.gnt0, if3.gnt1, if3.done0, if3.done1};
        checks++;
        if (o1 !== 4'b0) begin
            failures++;
            $display("FAIL reset_hs1 got=%b want=0000", o1);
        end
        checks++;
        if (o3 !== 4'b0) begin
            failures++;
            $display("FAIL reset_hs3 got=%b want=0000", o3);
        end
        checks++;
        if ({if1.memRead, if1.memWrite, if3.memRead, if3.memWrite} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b%b%b%b want=0000",
                     if1.memRead, if1.memWrite, if3.memRead, if3.memWrite);
        end
        checks++;
        if ({if1.rdata, if1.adress, if1.data} !== 96'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h/%h/%h want=0",
                     if1.rdata, if1.adress, if1.data);
        end
        reset = 0;
        tick();
        checks++;
        if ({if1.gnt0, if1.gnt1, if3.gnt0, if3.gnt1} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle_gnt got=%b%b%b%b want=0000",
                     if1.gnt0, if1.gnt1, if3.gnt0, if3.gnt1);
        end
    endtask

    task automatic test_cpu_read();
        logic e_rd;
        logic e_gnt;
        logic e_done;
        do_reset();
        if1.req0  = 1;
        if1.we0   = 0;
        if1.addr0 = 32'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            e_rd   = (i == 0);
            e_gnt  = (i < 3);
            e_done = (i == 2);
            checks++;
            if ({if1.memRead, if1.memWrite, if1.gnt0, if1.gnt1, if1.done0, if1.done1}
                !== {e_rd, 1'b0, e_gnt, 1'b0, e_done, 1'b0}) begin
                failures++;
                $display("FAIL cpu_read_c%0d got rd=%b wr=%b g=%b%b d=%b%b want rd=%b g0=%b d0=%b",
                         i + 2, if1.memRead, if1.memWrite, if1.gnt0, if1.gnt1,
                         if1.done0, if1.done1, e_rd, e_gnt, e_done);
            end
            if (i == 0) begin
                checks++;
                if (if1.adress !== 32'h10) begin
                    failures++;
                    $display("FAIL cpu_read_adress got=%h want=00000010", if1.adress);
                end
            end
            if (i == 2) begin
                checks++;
                if (if1.rdata !== 32'hCAFE0001) begin
                    failures++;
                    $display("FAIL cpu_read_rdata got=%h want=cafe0001", if1.rdata);
                end
                if1.req0 = 0;
            end
        end
    endtask

    task automatic test_load_write();
        logic e_wr;
        logic e_gnt;
        logic e_done;
        do_reset();
        if3.req1   = 1;
        if3.we1    = 1;
        if3.addr1  = 32'h20;
        if3.wdata1 = 32'h55;
        for (int i = 0; i < 6; i++) begin
            tick();
            e_wr   = (i == 0);
            e_gnt  = (i < 5);
            e_done = (i == 4);
            checks++;
            if ({if3.memRead, if3.memWrite, if3.gnt0, if3.gnt1, if3.done0, if3.done1}
                !== {1'b0, e_wr, 1'b0, e_gnt, 1'b0, e_done}) begin
                failures++;
                $display("FAIL load_write_c%0d got rd=%b wr=%b g=%b%b d=%b%b want wr=%b g1=%b d1=%b",
                         i + 2, if3.memRead, if3.memWrite, if3.gnt0, if3.gnt1,
                         if3.done0, if3.done1, e_wr, e_gnt, e_done);
            end
            if (i == 0) begin
                checks++;
                if ({if3.adress, if3.data} !== {32'h20, 32'h55}) begin
                    failures++;
                    $display("FAIL load_write_bus got=%h/%h want=00000020/00000055",
                             if3.adress, if3.data);
                end
            end
            if (i == 4) begin
                checks++;
                if (if3.rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL load_write_rdata got=%h want=00000000", if3.rdata);
                end
                if3.req1 = 0;
            end
        end
        checks++;
        if (m3[8'h20] !== 32'h55) begin
            failures++;
            $display("FAIL load_write_mem got=%h want=00000055", m3[8'h20]);
        end
        if3.we1 = 0;
    endtask

    task automatic test_back_to_back();
        logic e_d0;
        logic e_d1;
        do_reset();
        if1.req0  = 1;
        if1.req1  = 1;
        if1.we0   = 0;
        if1.we1   = 0;
        if1.addr0 = 32'h10;
        if1.addr1 = 32'h11;
        for (int i = 0; i < 15; i++) begin
            tick();
            e_d0 = ((i % 8) == 2);
            e_d1 = ((i % 8) == 6);
            checks++;
            if ({if1.done0, if1.done1, if1.gnt0 & if1.gnt1} !== {e_d0, e_d1, 1'b0}) begin
                failures++;
                $display("FAIL rr_c%0d got d=%b%b g=%b%b want d=%b%b no overlap",
                         i, if1.done0, if1.done1, if1.gnt0, if1.gnt1, e_d0, e_d1);
            end
            if (e_d0) begin
                checks++;
                if (if1.rdata !== 32'hCAFE0001) begin
                    failures++;
                    $display("FAIL rr_rdata0_c%0d got=%h want=cafe0001", i, if1.rdata);
                end
            end
            if (e_d1) begin
                checks++;
                if (if1.rdata !== 32'h11110000) begin
                    failures++;
                    $display("FAIL rr_rdata1_c%0d got=%h want=11110000", i, if1.rdata);
                end
            end
        end
        if1.req0 = 0;
        if1.req1 = 0;
        tick();
    endtask

    task automatic test_boot();
        logic e_d0;
        logic e_d1;
        logic e_g0;
        logic e_g1;
        do_reset();
        if1.boot  = 1;
        if1.req0  = 1;
        if1.req1  = 1;
        if1.addr0 = 32'h10;
        if1.addr1 = 32'h11;
        for (int i = 0; i < 15; i++) begin
            tick();
            e_g1 = (i <= 10) && ((i % 4) != 3);
            e_g0 = (i >= 12);
            e_d1 = (i == 2) || (i == 6) || (i == 10);
            e_d0 = (i == 14);
            checks++;
            if ({if1.gnt0, if1.gnt1, if1.done0, if1.done1} !== {e_g0, e_g1, e_d0, e_d1}) begin
                failures++;
                $display("FAIL boot_c%0d got g=%b%b d=%b%b want g=%b%b d=%b%b",
                         i, if1.gnt0, if1.gnt1, if1.done0, if1.done1,
                         e_g0, e_g1, e_d0, e_d1);
            end
            if (i == 9) if1.boot = 0;
        end
        if1.req0 = 0;
        if1.req1 = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        if1.req0  = 1;
        if1.addr0 = 32'h10;
        tick();
        checks++;
        if ({if1.gnt0, if1.memRead} !== 2'b11) begin
            failures++;
            $display("FAIL rmid_issue got g0=%b rd=%b want 1 1", if1.gnt0, if1.memRead);
        end
        tick();
        if1.req1 = 1;
        reset    = 1;
        tick();
        reset = 0;
        checks++;
        if ({if1.gnt0, if1.gnt1, if1.done0, if1.done1, if1.memRead, if1.memWrite}
            !== 6'b0) begin
            failures++;
            $display("FAIL rmid_ctrl got g=%b%b d=%b%b rd=%b wr=%b want all 0",
                     if1.gnt0, if1.gnt1, if1.done0, if1.done1,
                     if1.memRead, if1.memWrite);
        end
        checks++;
        if ({if1.rdata, if1.adress, if1.data} !== 96'h0) begin
            failures++;
            $display("FAIL rmid_bus got=%h/%h/%h want=0",
                     if1.rdata, if1.adress, if1.data);
        end
        tick();
        checks++;
        if ({if1.gnt0, if1.gnt1} !== 2'b10) begin
            failures++;
            $display("FAIL rmid_first_grant got g=%b%b want 10", if1.gnt0, if1.gnt1);
        end
        if1.req0 = 0;
        if1.req1 = 0;
        tick();
        tick();
        checks++;
        if ({if1.done0, if1.done1} !== 2'b10) begin
            failures++;
            $display("FAIL rmid_done got d=%b%b want 10", if1.done0, if1.done1);
        end
        tick();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1;
        idle_inputs();
        for (int i = 0; i < 256; i++) m1[i] = 32'h0;
        m1[8'h10] = 32'hCAFE0001;
        m1[8'h11] = 32'h11110000;
        test_reset();
        test_cpu_read();
        test_load_write();
        test_back_to_back();
        test_boot();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
